// File: rtl/vx_tensor_gpr_bank_pkg.sv
// vx_tensor_gpr_bank_pkg: shared widths and the GPR bank address encoding.
// Collectors and the bank both call gpr_bank_addr so they agree on the packing.
package vx_tensor_gpr_bank_pkg;
    localparam int GPR_NUM_REQS  = 2;
    localparam int ISSUE_WIS_W   = 2;
    localparam int SIMD_IDX_W    = 1;
    localparam int NR_BITS       = 6;
    localparam int SIMD_WIDTH    = 4;
    localparam int XLEN          = 32;
    localparam int SRC_OPD_WIDTH = 2;
    localparam int GPR_ADDR_W    = ISSUE_WIS_W + SIMD_IDX_W + NR_BITS;
    localparam int GPR_DATA_W    = SIMD_WIDTH * XLEN;

    function automatic logic [GPR_ADDR_W-1:0] gpr_bank_addr(
        input logic [ISSUE_WIS_W-1:0] wis,
        input logic [SIMD_IDX_W-1:0]  sid,
        input logic [NR_BITS-1:0]     reg_id
    );
        return {wis, sid, reg_id};
    endfunction
endpackage

// File: rtl/vx_tensor_gpr_ram.sv
// vx_tensor_gpr_ram: 1R1W synchronous RAM with per-lane write enables.
// A read colliding with a write on the same edge sees the written lanes (write-first).
module vx_tensor_gpr_ram #(
    parameter int AW    = 9,
    parameter int LANES = 4,
    parameter int LW    = 32
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [LANES-1:0]      i_wmask,
    input  logic [LANES*LW-1:0]   i_wdata,
    input  logic                  i_re,
    input  logic [AW-1:0]         i_raddr,
    output logic [LANES*LW-1:0]   o_rdata
);
    logic [LANES*LW-1:0] r_mem [2**AW];
    logic [LANES*LW-1:0] r_rdata;
    logic [LANES*LW-1:0] w_fwd;

    always_comb begin
        w_fwd = r_mem[i_raddr];
        for (int l = 0; l < LANES; l++)
            if (i_we && i_wmask[l] && (i_waddr == i_raddr))
                w_fwd[l*LW +: LW] = i_wdata[l*LW +: LW];
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++)
            if (i_we && i_wmask[l])
                r_mem[i_waddr][l*LW +: LW] <= i_wdata[l*LW +: LW];
        if (i_re)
            r_rdata <= w_fwd;
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/vx_tensor_gpr_bank.sv
// vx_tensor_gpr_bank: round-robin arbitrated GPR read port with one writeback port.
// One read is granted per cycle; its tagged response returns exactly one cycle later.
module vx_tensor_gpr_bank
    import vx_tensor_gpr_bank_pkg::*;
#(
    parameter int NUM_REQS = GPR_NUM_REQS
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQS-1:0]               req_valid,
    output logic [NUM_REQS-1:0]               req_ready,
    input  logic [NUM_REQS*SRC_OPD_WIDTH-1:0] req_opd_id,
    input  logic [NUM_REQS*SIMD_IDX_W-1:0]    req_sid,
    input  logic [NUM_REQS*ISSUE_WIS_W-1:0]   req_wis,
    input  logic [NUM_REQS*NR_BITS-1:0]       req_reg_id,
    output logic [NUM_REQS-1:0]               rsp_valid,
    output logic [SRC_OPD_WIDTH-1:0]          rsp_opd_id,
    output logic [GPR_DATA_W-1:0]             rsp_data,
    input  logic                              wb_valid,
    input  logic [ISSUE_WIS_W-1:0]            wb_wis,
    input  logic [SIMD_IDX_W-1:0]             wb_sid,
    input  logic [NR_BITS-1:0]                wb_reg_id,
    input  logic [SIMD_WIDTH-1:0]             wb_tmask,
    input  logic [GPR_DATA_W-1:0]             wb_data
);
    localparam int PW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    logic [PW-1:0]            r_ptr;
    logic [NUM_REQS-1:0]      r_rsp_valid;
    logic [SRC_OPD_WIDTH-1:0] r_rsp_opd;
    logic                     r_zero;
    logic                     w_any;
    logic [PW-1:0]            w_idx;
    logic [NR_BITS-1:0]       w_reg;
    logic [GPR_ADDR_W-1:0]    w_raddr;
    logic [GPR_DATA_W-1:0]    w_rdata;
    logic                     w_we;

    // Scan downward so the requester closest to the pointer is assigned last and wins.
    always_comb begin
        w_any = 1'b0;
        w_idx = '0;
        for (int i = NUM_REQS - 1; i >= 0; i--)
            if (req_valid[(int'(r_ptr) + i) % NUM_REQS]) begin
                w_any = 1'b1;
                w_idx = PW'((int'(r_ptr) + i) % NUM_REQS);
            end
    end

    assign req_ready = {NUM_REQS{w_any}} & (NUM_REQS'(1) << w_idx);
    assign w_reg     = req_reg_id[w_idx*NR_BITS +: NR_BITS];
    assign w_raddr   = gpr_bank_addr(req_wis[w_idx*ISSUE_WIS_W +: ISSUE_WIS_W],
                                     req_sid[w_idx*SIMD_IDX_W +: SIMD_IDX_W], w_reg);
    // Register 0 is never written; reads of it are forced to zero at the output.
    assign w_we      = wb_valid && (wb_reg_id != '0);

    vx_tensor_gpr_ram #(
        .AW    (GPR_ADDR_W),
        .LANES (SIMD_WIDTH),
        .LW    (XLEN)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (gpr_bank_addr(wb_wis, wb_sid, wb_reg_id)),
        .i_wmask (wb_tmask),
        .i_wdata (wb_data),
        .i_re    (w_any),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr       <= '0;
            r_rsp_valid <= '0;
            r_rsp_opd   <= '0;
            r_zero      <= 1'b0;
        end else begin
            r_rsp_valid <= req_ready;
            if (w_any) begin
                r_ptr     <= (w_idx == PW'(NUM_REQS - 1)) ? '0 : w_idx + 1'b1;
                r_rsp_opd <= req_opd_id[w_idx*SRC_OPD_WIDTH +: SRC_OPD_WIDTH];
                r_zero    <= (w_reg == '0);
            end
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_opd_id = r_rsp_opd;
    assign rsp_data   = (|r_rsp_valid && !r_zero) ? w_rdata : '0;
endmodule

// File: doc/vx_tensor_gpr_bank.md
Name: vx_tensor_gpr_bank

Overview:
GPR responder serving operand-fetch read requests from up to NUM_REQS tensor operand collectors, plus one writeback write port. Storage is one register file slice per issue slot, addressed by {wis, sid, reg_id}, holding SIMD_WIDTH lanes of XLEN bits per entry. Each cycle it arbitrates one read request round-robin, reads synchronously, and returns the tagged response exactly one cycle later. The response has no back-pressure.

Parameters:
NUM_REQS, 2, number of requesting operand collectors
ISSUE_WIS_W, 2, warp-in-slot index width
SIMD_IDX_W, 1, SIMD segment index width (SIMD_COUNT = 2**SIMD_IDX_W)
NR_BITS, 6, register number width (NUM_REGS = 2**NR_BITS)
SIMD_WIDTH, 4, lanes per entry
XLEN, 32, lane width
OPD_W, 2, operand id tag width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
req_valid  in  NUM_REQS  per-requester read request valid
req_ready  out  NUM_REQS  per-requester grant (request fired)
req_opd_id  in  NUM_REQS*OPD_W  operand tag
req_sid  in  NUM_REQS*SIMD_IDX_W  SIMD segment
req_wis  in  NUM_REQS*ISSUE_WIS_W  warp-in-slot
req_reg_id  in  NUM_REQS*NR_BITS  register number
rsp_valid  out  NUM_REQS  one-hot response valid, routed to the original requester
rsp_opd_id  out  OPD_W  echoed tag
rsp_data  out  SIMD_WIDTH*XLEN  read data, lane 0 in LSBs
wb_valid  in  1  writeback valid (always accepted)
wb_wis  in  ISSUE_WIS_W  writeback warp-in-slot
wb_sid  in  SIMD_IDX_W  writeback segment
wb_reg_id  in  NR_BITS  writeback register
wb_tmask  in  SIMD_WIDTH  lane write enables
wb_data  in  SIMD_WIDTH*XLEN  writeback data

Behaviour:
- Reset (async, active-high):
  - rsp_valid=0, rsp_opd_id=0, rsp_data=0.
  - Round-robin pointer=0.
  - Storage contents are not reset. In simulation non-NDEBUG builds (GPR_RESET), all entries are cleared to 0.
- Arbitration:
  - Combinational round-robin over req_valid, starting at the pointer.
  - req_ready is one-hot: it equals the winner's bit and is asserted only when that requester's valid=1. req_ready=0 when no request is valid.
  - Requesters must hold their request until ready. A request is not dropped while it is not granted.
  - After a grant, the pointer moves to winner+1 modulo NUM_REQS. With no grant, the pointer holds.
- Read pipeline, latency 1:
  - On the grant edge, capture address {wis,sid,reg_id}, opd_id and the one-hot requester.
  - Next cycle: rsp_valid[requester]=1 with data. Otherwise rsp_valid=0.
  - Sustained throughput is 1 response/cycle.
- Register 0 is hardwired zero:
  - Reads of reg_id 0 return all-zero data.
  - Writebacks to reg 0 are ignored.
- Writeback:
  - When wb_valid, on the edge, write wb_data lanes where wb_tmask[i]=1. Other lanes hold.
  - wb_tmask=0 makes the writeback a no-op.
- Read/write same address, same edge: the response returns the new data for lanes with tmask=1 and the old data for the other lanes (write-first forwarding).
- Writeback in cycle N to an address read-granted in cycle N+1: the response carries the new data (ordinary RAM semantics).
- Only one read port exists. With all NUM_REQS requesters valid continuously, each is granted once every NUM_REQS cycles (no starvation).
- Reset asserted while a response is in flight: the response is dropped, and rsp_valid=0 immediately (async).
- Index widths are exact; no wrap or overflow logic is needed. Depth = 2**(ISSUE_WIS_W+SIMD_IDX_W+NR_BITS).

Decomposition:
- Widths and constants (ISSUE_WIS_W, SIMD_IDX_W, NR_BITS, SRC_OPD_WIDTH) come from VX_gpu_pkg. Add a gpr_bank address packing function to the package so collectors and the bank share one encoding.
- Sub-module vx_tensor_gpr_ram: 1R1W synchronous RAM with per-lane write enable and write-first forwarding.
- Arbitration reuses the existing VX_rr_arbiter.

Test Plan:
1. Write wis=1,sid=0,reg=5, tmask=1111, data lanes {0x11,0x22,0x33,0x44}; next cycle req0 reads the same address with opd_id=2 -> req_ready[0]=1 that cycle; next cycle rsp_valid=01, rsp_opd_id=2, data={0x11,0x22,0x33,0x44}.
2. Requests 0 and 1 both valid for 4 cycles, pointer=0 -> grants 0,1,0,1. Responses arrive 1 cycle later with rsp_valid 01,10,01,10 and the correct tags.
3. Write reg 7 = all 0xAAAAAAAA. Then in one cycle, wb tmask=0101 data all 0x55555555 while reading reg 7 -> response lanes {0x55555555,0xAAAAAAAA,0x55555555,0xAAAAAAAA}.
4. Writeback to reg 0 with data 0xFFFFFFFF, then read reg 0 -> data all zero.
5. Grant in cycle N, reset asserted mid-cycle N+1 -> rsp_valid drops to 0 immediately. After reset release, the first two-way contention grants requester 0.
6. Writes to wis=0,sid=1,reg=9 and wis=0,sid=0,reg=9 with distinct data -> each read returns only its own data (addressing isolation).
